// File: rtl/sobel_window_gen.sv
// sobel_window_gen: 3x3 raster window generator with two line stores.
// Two-stage pipeline (store read, window shift) with valid/ready handshakes.
module sobel_window_gen #(
  parameter int WIDTH_P        = 8,
  parameter int LINE_WIDTH_P   = 640,
  parameter int FRAME_HEIGHT_P = 480
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [WIDTH_P-1:0]     data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [9*WIDTH_P-1:0]   window_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam int CW = (LINE_WIDTH_P > 1) ? $clog2(LINE_WIDTH_P) : 1;
  localparam int RW = (FRAME_HEIGHT_P > 1) ? $clog2(FRAME_HEIGHT_P) : 1;

  typedef logic [WIDTH_P-1:0] pix_t;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last;
  logic          row_last;

  pix_t line1 [LINE_WIDTH_P];
  pix_t line2 [LINE_WIDTH_P];
  pix_t rd1;
  pix_t rd2;

  pix_t pix_s1;
  logic s1_v;
  logic s1_emit;

  pix_t win [9];
  logic out_v;

  logic stall;
  logic accept;

  // Only a held, untransferred window blocks the pipe.
  assign stall    = out_v && !ready_i;
  assign ready_o  = !rst_i && (!out_v || ready_i);
  assign valid_o  = out_v && !rst_i;
  assign accept   = valid_i && ready_o;

  assign col_last = (col == CW'(LINE_WIDTH_P - 1));
  assign row_last = (row == RW'(FRAME_HEIGHT_P - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Registered read, read-before-write: line r-1 ages into line r-2.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      rd1        <= line1[col];
      rd2        <= line2[col];
      line1[col] <= data_i;
      line2[col] <= line1[col];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v <= 1'b0;
    end else if (!stall) begin
      s1_v <= accept;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      pix_s1  <= data_i;
      s1_emit <= (row >= RW'(2)) && (col >= CW'(2));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_v <= 1'b0;
    end else if (!stall) begin
      out_v <= s1_v && s1_emit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!stall && s1_v) begin
      for (int r = 0; r < 3; r++) begin
        win[3*r]   <= win[3*r+1];
        win[3*r+1] <= win[3*r+2];
      end
      win[2] <= rd2;
      win[5] <= rd1;
      win[8] <= pix_s1;
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_pack
    assign window_o[k*WIDTH_P +: WIDTH_P] = win[k];
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: randomized bench for sobel_window_gen.
// Windows are predicted from the pixel stream by plain 2-D indexing.
module tb_sobel_window_gen;

  localparam int W  = 8;
  localparam int LW = 4;
  localparam int FH = 4;
  localparam int FS = LW * FH;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [W-1:0]  data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [9*W-1:0] window_o;
  logic          valid_o;
  logic          ready_i = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0]   src [$];
  logic [9*W-1:0] got [$];
  int             got_cyc [$];
  logic [9*W-1:0] exp_q [$];
  int             exp_br [$];
  logic [9*W-1:0] stall_win [$];
  logic           stall_rdy [$];
  logic           stall_vo [$];
  int             acc_cyc [0:255];

  sobel_window_gen #(
    .WIDTH_P(W),
    .LINE_WIDTH_P(LW),
    .FRAME_HEIGHT_P(FH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .data_i(data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .window_o(window_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o && ready_i) begin
      got.push_back(window_o);
      got_cyc.push_back(cyc);
    end
  end

  task automatic build_exp();
    logic [9*W-1:0] w;
    exp_q.delete();
    exp_br.delete();
    for (int f = 0; f < src.size() / FS; f++)
      for (int r = 2; r < FH; r++)
        for (int c = 2; c < LW; c++) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              w[(3*i+j)*W +: W] = src[f*FS + (r-2+i)*LW + (c-2+j)];
          exp_q.push_back(w);
          exp_br.push_back(f*FS + r*LW + c);
        end
  endtask

  task automatic ramp(input int frames, input int base);
    src.delete();
    for (int f = 0; f < frames; f++)
      for (int i = 0; i < FS; i++)
        src.push_back(W'(i + f*base));
  endtask

  task automatic drive(input int first, input int last,
                       input int vpct, input int rpct,
                       input int stall_n);
    int  i;
    int  scnt;
    int  guard;
    bit  stalled;
    i = first;
    scnt = 0;
    guard = 0;
    stalled = (stall_n == 0);
    while (i < last) begin
      if (!stalled && valid_o) begin
        scnt = stall_n;
        stalled = 1'b1;
      end
      ready_i = (scnt > 0) ? 1'b0 : ($urandom_range(99) < rpct);
      valid_i = ($urandom_range(99) < vpct);
      data_i  = src[i];
      @(negedge clk);
      if (scnt > 0) begin
        stall_win.push_back(window_o);
        stall_rdy.push_back(ready_o);
        stall_vo.push_back(valid_o);
        scnt--;
      end
      if (valid_i && ready_o) begin
        acc_cyc[i] = cyc;
        i++;
      end
      @(posedge clk);
      #1;
      guard++;
      if (guard > 4000) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout accepted %0d required %0d", i, last);
        break;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic drain(input int n);
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    valid_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_o got %b expected 0", valid_o);
    end
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_o got %b expected 0", ready_o);
    end
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready_o got %b expected 1", ready_o);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_valid_o got %b expected 0", valid_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    ramp(1, 0);
    build_exp();
    got.delete();
    got_cyc.delete();
    drive(0, FS, 100, 100, 0);
    drain(8);
    checks++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL basic_count got %0d expected %0d", got.size(), exp_q.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL basic_win%0d got %h expected %h", k, got[k], exp_q[k]);
      end
      checks++;
      if (got_cyc[k] !== acc_cyc[exp_br[k]] + 2) begin
        errors++;
        $display("FAIL basic_latency%0d got cycle %0d expected %0d",
                 k, got_cyc[k], acc_cyc[exp_br[k]] + 2);
      end
    end
  endtask

  task automatic test_stall();
    ramp(1, 0);
    build_exp();
    got.delete();
    stall_win.delete();
    stall_rdy.delete();
    stall_vo.delete();
    drive(0, FS, 100, 100, 5);
    drain(8);
    checks++;
    if (stall_win.size() !== 5) begin
      errors++;
      $display("FAIL stall_cycles got %0d expected 5", stall_win.size());
    end
    for (int k = 0; k < stall_win.size(); k++) begin
      checks++;
      if (stall_win[k] !== exp_q[0] || stall_vo[k] !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d got %h/%b expected %h/1",
                 k, stall_win[k], stall_vo[k], exp_q[0]);
      end
      checks++;
      if (stall_rdy[k] !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready%0d got %b expected 0", k, stall_rdy[k]);
      end
    end
    checks++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL stall_count got %0d expected %0d", got.size(), exp_q.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL stall_win%0d got %h expected %h", k, got[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    ramp(2, 100);
    build_exp();
    got.delete();
    drive(0, 2*FS, 100, 100, 0);
    drain(8);
    checks++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d expected %0d", got.size(), exp_q.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL b2b_win%0d got %h expected %h", k, got[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_bubbles();
    ramp(1, 0);
    build_exp();
    got.delete();
    drive(0, FS, 50, 100, 0);
    drain(8);
    checks++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL bubble_count got %0d expected %0d", got.size(), exp_q.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL bubble_win%0d got %h expected %h", k, got[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_mid_reset(input int cut);
    ramp(1, 0);
    build_exp();
    got.delete();
    drive(0, cut, 100, 100, 0);
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst%0d_outputs got %b/%b expected 0/0",
               cut, valid_o, ready_o);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    drain(3);
    checks++;
    if (got.size() !== 0) begin
      errors++;
      $display("FAIL midrst%0d_discard got %0d windows expected 0", cut, got.size());
    end
    got.delete();
    drive(0, FS, 100, 100, 0);
    drain(8);
    checks++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL midrst%0d_count got %0d expected %0d",
               cut, got.size(), exp_q.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL midrst%0d_win%0d got %h expected %h",
                 cut, k, got[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    src.delete();
    for (int i = 0; i < 3*FS; i++)
      src.push_back(W'($urandom_range(255)));
    build_exp();
    got.delete();
    drive(0, 3*FS, 70, 60, 0);
    drain(10);
    checks++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL random_count got %0d expected %0d", got.size(), exp_q.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL random_win%0d got %h expected %h", k, got[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_bubbles();
    test_mid_reset(10);
    test_mid_reset(11);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
